// File: rtl/alu_control_seq_pkg.sv
// Shared ALU control constants: Signal codes, funct codes, ALUOp encodings,
// writeback select encodings and sequencer states, matching the ALU's decoder.
package alu_control_seq_pkg;

    localparam logic [5:0] SIG_NONE = 6'd0;
    localparam logic [5:0] SIG_ADD  = 6'd32;
    localparam logic [5:0] SIG_SUB  = 6'd34;
    localparam logic [5:0] SIG_AND  = 6'd36;
    localparam logic [5:0] SIG_OR   = 6'd37;
    localparam logic [5:0] SIG_SLT  = 6'd42;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_HI  = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_control_seq_funct_decode.sv
// Combinational ALUOp/funct decode into ALU Signal, HI/LO select, multiply
// request and illegal flag; zero latency, no flow control of its own.
module alu_funct_decode
    import alu_control_seq_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [5:0] signal_o,
    output logic [1:0] hilo_sel_o,
    output logic       is_mult_o,
    output logic       illegal_o
);

    always_comb begin
        signal_o   = SIG_NONE;
        hilo_sel_o = SEL_ALU;
        is_mult_o  = 1'b0;
        illegal_o  = 1'b0;
        case (aluop_i)
            ALUOP_ADD: signal_o = SIG_ADD;
            ALUOP_SUB: signal_o = SIG_SUB;
            ALUOP_SLT: signal_o = SIG_SLT;
            default: begin
                case (funct_i)
                    SIG_ADD, SIG_SUB, SIG_AND, SIG_OR, SIG_SLT: signal_o = funct_i;
                    FN_MFHI:  hilo_sel_o = SEL_HI;
                    FN_MFLO:  hilo_sel_o = SEL_LO;
                    FN_MULTU: is_mult_o  = 1'b1;
                    default:  illegal_o  = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: registered Signal decode (latency 1), HI/LO pair and
// 32-step shift-add MULTU; in_ready drops for the whole multiply sequence.
module alu_control_seq
    import alu_control_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             out_valid,
    output logic [5:0]       Signal,
    output logic [1:0]       hilo_sel,
    output logic [WIDTH-1:0] hilo_data,
    output logic             illegal
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               out_valid_q, out_valid_d;
    logic [5:0]         signal_q, signal_d;
    logic [1:0]         hilo_sel_q, hilo_sel_d;
    logic [WIDTH-1:0]   hilo_data_q, hilo_data_d;
    logic               illegal_q, illegal_d;

    logic [5:0]         dec_signal;
    logic [1:0]         dec_sel;
    logic               dec_mult;
    logic               dec_illegal;
    logic [WIDTH:0]     step_sum;

    alu_funct_decode u_decode (
        .aluop_i    (ALUOp),
        .funct_i    (funct),
        .signal_o   (dec_signal),
        .hilo_sel_o (dec_sel),
        .is_mult_o  (dec_mult),
        .illegal_o  (dec_illegal)
    );

    assign in_ready = (state_q == ST_IDLE);

    // Carry out of the add lands in bit WIDTH and shifts down into acc's MSB.
    assign step_sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = 1'b0;
        signal_d    = SIG_NONE;
        hilo_sel_d  = SEL_ALU;
        hilo_data_d = '0;
        illegal_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (dec_mult) begin
                        state_d  = ST_MUL;
                        mcand_d  = dataA;
                        mplier_d = dataB;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        signal_d    = dec_signal;
                        hilo_sel_d  = dec_sel;
                        illegal_d   = dec_illegal;
                        if (dec_sel == SEL_HI)
                            hilo_data_d = hi_q;
                        else if (dec_sel == SEL_LO)
                            hilo_data_d = lo_q;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = step_sum[WIDTH:1];
                mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == '1)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                hi_d        = acc_q;
                lo_d        = mplier_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            signal_q    <= SIG_NONE;
            hilo_sel_q  <= SEL_ALU;
            hilo_data_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            signal_q    <= signal_d;
            hilo_sel_q  <= hilo_sel_d;
            hilo_data_q <= hilo_data_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Signal    = signal_q;
    assign hilo_sel  = hilo_sel_q;
    assign hilo_data = hilo_data_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode, MULTU sequencing, HI/LO reads,
// hold-off while busy and reset mid-multiply.
module tb_alu_control_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        out_valid;
    logic [5:0]  Signal;
    logic [1:0]  hilo_sel;
    logic [31:0] hilo_data;
    logic        illegal;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_control_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .funct     (funct),
        .dataA     (dataA),
        .dataB     (dataB),
        .out_valid (out_valid),
        .Signal    (Signal),
        .hilo_sel  (hilo_sel),
        .hilo_data (hilo_data),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        ALUOp    = op;
        funct    = fn;
        dataA    = a;
        dataB    = b;
        step();
        in_valid = 1'b0;
    endtask

    // Waits out the busy window; returns busy-cycle count and out_valid pulses seen while busy.
    task automatic wait_busy(output int busy, output int early_vld);
        busy      = 0;
        early_vld = 0;
        while (!in_ready && busy < 100) begin
            busy++;
            if (out_valid) early_vld++;
            step();
        end
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy;
        int early;
        req(2'b10, 6'd25, a, b);
        wait_busy(busy, early);
        check({tag, "_busy_cycles"}, busy, 33);
        check({tag, "_early_vld"}, early, 0);
        check({tag, "_done_vld"}, out_valid, 1);
        check({tag, "_done_sig"}, Signal, 0);
        check({tag, "_done_sel"}, hilo_sel, 0);
        req(2'b10, 6'd16, '0, '0);
        check({tag, "_mfhi_sel"}, hilo_sel, 1);
        check({tag, "_mfhi"}, hilo_data, exp_hi);
        req(2'b10, 6'd18, '0, '0);
        check({tag, "_mflo_sel"}, hilo_sel, 2);
        check({tag, "_mflo"}, hilo_data, exp_lo);
        step();
        check({tag, "_idle_vld"}, out_valid, 0);
    endtask

    logic [5:0] fn_tab [5];
    logic [5:0] sig_tab [3];
    logic [1:0] op_tab [3];

    initial begin
        int busy;
        int early;
        fn_tab  = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42};
        op_tab  = '{2'b00, 2'b01, 2'b11};
        sig_tab = '{6'd32, 6'd34, 6'd42};

        reset    = 1'b1;
        in_valid = 1'b0;
        ALUOp    = 2'b00;
        funct    = 6'd0;
        dataA    = '0;
        dataB    = '0;
        step();
        step();
        check("rst_ready", in_ready, 1);
        check("rst_vld", out_valid, 0);
        check("rst_sig", Signal, 0);
        check("rst_data", hilo_data, 0);
        check("rst_illegal", illegal, 0);
        reset = 1'b0;
        step();

        // R-type ops back-to-back, one result per cycle
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            step();
            check("rtype_vld", out_valid, 1);
            check("rtype_sig", Signal, fn_tab[i]);
            check("rtype_ill", illegal, 0);
        end
        in_valid = 1'b0;
        step();
        check("rtype_after_vld", out_valid, 0);
        check("rtype_after_sig", Signal, 0);

        // Non-R-type ALUOp ignores funct
        for (int i = 0; i < 3; i++) begin
            req(op_tab[i], 6'h3F, '0, '0);
            check("aluop_vld", out_valid, 1);
            check("aluop_sig", Signal, sig_tab[i]);
            check("aluop_ill", illegal, 0);
        end

        run_mult("mul_a", 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 32'h242D2080);
        run_mult("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_mult("mul_zero", 32'h0, 32'h5, 32'h0, 32'h0);

        // Request held during MUL is accepted only once in_ready returns
        req(2'b10, 6'd25, 32'd3, 32'd4);
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        funct    = 6'd32;
        wait_busy(busy, early);
        check("hold_busy", busy, 33);
        check("hold_early_vld", early, 0);
        check("hold_done_sig", Signal, 0);
        step();
        check("hold_vld", out_valid, 1);
        check("hold_sig", Signal, 32);
        in_valid = 1'b0;
        step();
        check("hold_once", out_valid, 0);
        req(2'b10, 6'd18, '0, '0);
        check("hold_mflo", hilo_data, 12);

        // Reset ten cycles into a multiply aborts it and clears HI/LO
        req(2'b10, 6'd25, 32'h7, 32'h9);
        for (int i = 0; i < 9; i++) step();
        check("abort_busy", in_ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", in_ready, 1);
        check("abort_vld", out_valid, 0);
        req(2'b10, 6'd16, '0, '0);
        check("abort_mfhi_vld", out_valid, 1);
        check("abort_mfhi", hilo_data, 0);
        req(2'b10, 6'd7, '0, '0);
        check("illegal_vld", out_valid, 1);
        check("illegal_flag", illegal, 1);
        check("illegal_sig", Signal, 0);
        step();
        check("illegal_clear", illegal, 0);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) check("abort_no_late_vld", out_valid, 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
